// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE matrix job sequencer.
// Holds the state encoding, the matrix dimension and the kernel-size decode.
package pe_ctrl_pkg;

   localparam int MAT_DIM = 11;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      WPULSE,
      CLR,
      COMPUTE,
      DRAIN,
      OUT
   } state_t;

   // Kernel edge length for a given mode select: 00=3, 01=5, 10=7, 11=11.
   function automatic logic [3:0] kernel_of(input logic [1:0] sel);
      logic [3:0] k;
      case (sel)
         2'b00:   k = 4'd3;
         2'b01:   k = 4'd5;
         2'b10:   k = 4'd7;
         default: k = 4'd11;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/pe_ctrl_cnt.sv
// Loadable up/down counter that saturates at a terminal value and flags it.
// Used by the sequencer for the IF beat count and the pipeline drain count.
module pe_ctrl_cnt #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         up,
   input  logic [W-1:0] term,
   output logic         last
);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !last) begin
         count <= up ? count + 1'b1 : count - 1'b1;
      end
   end

   assign last = (count == term);

endmodule

// File: rtl/pe_matrix_seq_ctrl.sv
// Job sequencer for the 11x11 PE matrix: weight load, accumulator clear,
// IF streaming, pipeline drain and result handshake, with synchronous abort.
module pe_matrix_seq_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int STEP_W    = 8,
   parameter int PIPE_LAT  = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_sel,
   input  logic [STEP_W-1:0] cfg_steps,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic              abort,
   output logic [1:0]        pe_sel,
   output logic              pe_rst_w,
   output logic              pe_rst,
   output logic              pe_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int DRAIN_MAX = PIPE_LAT + MAT_DIM - 1;
   localparam int DRAIN_W   = $clog2(DRAIN_MAX + 1);

   if (DataWidth < 1 || PIPE_LAT < 0) begin : g_bad_param
      $error("pe_matrix_seq_ctrl: DataWidth must be >= 1 and PIPE_LAT >= 0");
   end

   state_t              state, next_state;
   logic [1:0]          sel_q;
   logic [STEP_W-1:0]   steps_q;
   logic [STEP_W-1:0]   step_term;
   logic [DRAIN_W-1:0]  drain_init;
   logic                abort_pulse_q;
   logic                pe_rst_clr;
   logic                cfg_hs, if_hs;
   logic                step_last, drain_last;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= IDLE;
         sel_q         <= 2'b00;
         steps_q       <= '0;
         abort_pulse_q <= 1'b0;
      end else begin
         state         <= next_state;
         abort_pulse_q <= abort && (state != IDLE);
         if (cfg_hs) begin
            sel_q   <= cfg_sel;
            steps_q <= (cfg_steps == '0) ? STEP_W'(1) : cfg_steps;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      next_state = state;
      cfg_ready  = 1'b0;
      w_ready    = 1'b0;
      if_ready   = 1'b0;
      pe_rst_w   = 1'b0;
      pe_rst_clr = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) next_state = LOAD_W;
         end
         LOAD_W: begin
            w_ready = 1'b1;
            if (w_valid) next_state = WPULSE;
         end
         WPULSE: begin
            pe_rst_w   = 1'b1;
            next_state = CLR;
         end
         CLR: begin
            pe_rst_clr = 1'b1;
            next_state = COMPUTE;
         end
         COMPUTE: begin
            if_ready = 1'b1;
            if (if_valid && step_last) next_state = DRAIN;
         end
         DRAIN: begin
            if (drain_last) next_state = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      // Abort wins over any handshake in the same cycle; in IDLE it simply holds IDLE.
      if (abort) begin
         cfg_ready  = 1'b0;
         w_ready    = 1'b0;
         if_ready   = 1'b0;
         next_state = IDLE;
      end
   end

   assign cfg_hs = cfg_valid & cfg_ready;
   assign if_hs  = if_valid & if_ready;
   assign pe_en  = if_hs;
   assign pe_rst = pe_rst_clr | abort_pulse_q;
   assign pe_sel = sel_q;
   assign busy   = (state != IDLE);

   assign step_term  = steps_q - STEP_W'(1);
   assign drain_init = DRAIN_W'(PIPE_LAT - 1) + DRAIN_W'(kernel_of(sel_q));

   pe_ctrl_cnt #(.W(STEP_W)) u_step_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .load     (cfg_hs),
      .load_val ('0),
      .en       (if_hs),
      .up       (1'b1),
      .term     (step_term),
      .last     (step_last)
   );

   // Counts down the PE pipeline plus the kernel sweep after the last IF beat.
   pe_ctrl_cnt #(.W(DRAIN_W)) u_drain_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .load     (if_hs & step_last),
      .load_val (drain_init),
      .en       (state == DRAIN),
      .up       (1'b0),
      .term     (DRAIN_W'(1)),
      .last     (drain_last)
   );

endmodule

// File: tb/tb_pe_matrix_seq_ctrl.sv
// Self-checking bench for pe_matrix_seq_ctrl: directed and randomized jobs
// checked against a job-level model (beat count, pulse counts, result latency).
module tb_pe_matrix_seq_ctrl;

   localparam int STEP_W   = 8;
   localparam int PIPE_LAT = 2;

   logic              CLK = 1'b0;
   logic              RST;
   logic              cfg_valid, cfg_ready;
   logic [1:0]        cfg_sel;
   logic [STEP_W-1:0] cfg_steps;
   logic              w_valid, w_ready;
   logic              if_valid, if_ready;
   logic              abort;
   logic [1:0]        pe_sel;
   logic              pe_rst_w, pe_rst, pe_en;
   logic              out_valid, out_ready;
   logic              busy;

   pe_matrix_seq_ctrl #(.DataWidth(8), .STEP_W(STEP_W), .PIPE_LAT(PIPE_LAT)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_sel   (cfg_sel),
      .cfg_steps (cfg_steps),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .if_valid  (if_valid),
      .if_ready  (if_ready),
      .abort     (abort),
      .pe_sel    (pe_sel),
      .pe_rst_w  (pe_rst_w),
      .pe_rst    (pe_rst),
      .pe_en     (pe_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   // Event monitor, sampled on the falling edge.
   int   cyc = 0, beats = 0, last_beat = 0;
   int   wcnt = 0, wcyc = 0, rcnt = 0, rcyc = 0;
   int   ov_rises = 0, ov_rise_cyc = 0, sel_err = 0;
   logic ov_prev = 1'b0;
   logic [1:0] exp_sel = 2'b00;

   always @(negedge CLK) begin
      cyc++;
      if (pe_en === 1'b1) begin beats++; last_beat = cyc; end
      if (pe_rst_w === 1'b1) begin wcnt++; wcyc = cyc; end
      if (pe_rst === 1'b1) begin rcnt++; rcyc = cyc; end
      if (out_valid === 1'b1 && ov_prev !== 1'b1) begin ov_rises++; ov_rise_cyc = cyc; end
      ov_prev = out_valid;
      if (busy === 1'b1 && pe_sel !== exp_sel) sel_err++;
   end

   // Reference: kernel edge per mode and the job-level expectations derived from it.
   int kdim[4] = '{3, 5, 7, 11};
   int b0, w0, r0, o0, s0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_job(input logic [1:0] sel, input logic [STEP_W-1:0] steps, input string tag);
      exp_sel   = sel;
      b0 = beats; w0 = wcnt; r0 = rcnt; o0 = ov_rises; s0 = sel_err;
      cfg_valid = 1'b1;
      cfg_sel   = sel;
      cfg_steps = steps;
      step();
      cfg_valid = 1'b0;
      cfg_sel   = 2'($urandom);
      cfg_steps = STEP_W'($urandom);
      #1;
      check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_if_ready(input string tag);
      int g = 0;
      while (if_ready !== 1'b1 && g < 50) begin step(); g++; end
      check({tag, "_reach_compute"}, 32'(if_ready), 32'd1);
   endtask

   task automatic feed(input int n, input bit rnd);
      int g = 0;
      while (beats - b0 < n && g < 2000) begin
         if_valid = rnd ? (($urandom % 2) == 1) : 1'b1;
         step();
         g++;
      end
      if_valid = 1'b0;
   endtask

   task automatic finish_job(input int k, input int exp_beats, input int hold, input string tag);
      int g = 0;
      while (out_valid !== 1'b1 && g < 300) begin step(); g++; end
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      for (int i = 0; i < hold; i++) begin
         step();
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_busy"}, 32'(busy), 32'd1);
         check({tag, "_hold_cfg_ready"}, 32'(cfg_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_idle_cfg_ready"}, 32'(cfg_ready), 32'd1);
      check({tag, "_beats"}, 32'(beats - b0), 32'(exp_beats));
      check({tag, "_wpulse_cycles"}, 32'(wcnt - w0), 32'd1);
      check({tag, "_rpulse_cycles"}, 32'(rcnt - r0), 32'd1);
      check({tag, "_clr_after_w"}, 32'(rcyc - wcyc), 32'd1);
      check({tag, "_latency"}, 32'(ov_rise_cyc - last_beat), 32'(PIPE_LAT + k));
      check({tag, "_out_rises"}, 32'(ov_rises - o0), 32'd1);
      check({tag, "_sel_stable"}, 32'(sel_err - s0), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]        rsel;
      logic [STEP_W-1:0] rsteps;
      int                rhold;
      logic [4:0]        pat;

      RST = 1'b0; cfg_valid = 1'b0; cfg_sel = 2'b00; cfg_steps = '0;
      w_valid = 1'b1; if_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pe_sel", 32'(pe_sel), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_pulses", 32'({pe_rst_w, pe_rst, pe_en}), 32'd0);
      RST = 1'b1;
      step();
      check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);

      // 3x3, 4 beats, everything ready.
      start_job(2'b00, 8'd4, "t2");
      feed(4, 1'b0);
      finish_job(kdim[0], 4, 0, "t2");

      // 11x11, 3 beats with a gappy IF stream.
      start_job(2'b11, 8'd3, "t3");
      wait_if_ready("t3");
      pat = 5'b10101;
      for (int i = 4; i >= 0; i--) begin
         if_valid = pat[i];
         step();
      end
      if_valid = 1'b0;
      finish_job(kdim[3], 3, 0, "t3");

      // Result back-pressure for 10 cycles.
      start_job(2'b10, 8'd2, "t4");
      feed(2, 1'b1);
      finish_job(kdim[2], 2, 10, "t4");

      // Zero step count runs a single beat.
      start_job(2'b01, 8'd0, "t6");
      feed(1, 1'b0);
      repeat (3) step();
      finish_job(kdim[1], 1, 0, "t6");

      // Abort during drain.
      start_job(2'b00, 8'd2, "ab_drain");
      feed(2, 1'b0);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      #1;
      check("ab_drain_busy", 32'(busy), 32'd0);
      check("ab_drain_pe_rst", 32'(pe_rst), 32'd1);
      step();
      check("ab_drain_pe_rst_width", 32'(pe_rst), 32'd0);
      repeat (20) step();
      check("ab_drain_no_out", 32'(ov_rises - o0), 32'd0);
      check("ab_drain_rpulses", 32'(rcnt - r0), 32'd2);

      // Abort coinciding with an IF handshake.
      start_job(2'b10, 8'd5, "ab_if");
      wait_if_ready("ab_if");
      if_valid = 1'b1;
      step();
      abort = 1'b1;
      #1;
      check("ab_if_pe_en_forced", 32'(pe_en), 32'd0);
      check("ab_if_ready_forced", 32'(if_ready), 32'd0);
      step();
      abort = 1'b0;
      if_valid = 1'b0;
      #1;
      check("ab_if_busy", 32'(busy), 32'd0);
      check("ab_if_pe_rst", 32'(pe_rst), 32'd1);
      repeat (20) step();
      check("ab_if_beats", 32'(beats - b0), 32'd1);
      check("ab_if_no_out", 32'(ov_rises - o0), 32'd0);

      // Randomized jobs against the job-level model.
      for (int j = 0; j < 6; j++) begin
         rsel   = 2'($urandom);
         rsteps = STEP_W'($urandom_range(6, 0));
         rhold  = int'($urandom_range(4, 0));
         start_job(rsel, rsteps, "rnd");
         feed((rsteps == 0) ? 1 : int'(rsteps), 1'b1);
         finish_job(kdim[rsel], (rsteps == 0) ? 1 : int'(rsteps), rhold, "rnd");
      end

      // Maximum step count.
      start_job(2'b01, 8'hFF, "max");
      feed(255, 1'b0);
      finish_job(kdim[1], 255, 1, "max");

      // Asynchronous reset in the middle of streaming.
      start_job(2'b11, 8'd10, "rst_mid");
      wait_if_ready("rst_mid");
      if_valid = 1'b1;
      step();
      step();
      #2;
      RST = 1'b0;
      #1;
      check("rst_mid_pe_en", 32'(pe_en), 32'd0);
      check("rst_mid_if_ready", 32'(if_ready), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_pe_sel", 32'(pe_sel), 32'd0);
      check("rst_mid_pulses", 32'({pe_rst_w, pe_rst, out_valid, w_ready}), 32'd0);
      if_valid = 1'b0;
      step();
      RST = 1'b1;
      step();
      check("rst_mid_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst_mid_idle", 32'(busy), 32'd0);

      // Recovery after reset.
      start_job(2'b01, 8'd3, "recover");
      feed(3, 1'b1);
      finish_job(kdim[1], 3, 2, "recover");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
